// File: rtl/scr1_mem_responder_if.sv
// scr1_mem_responder_if: SCR1 memory request/ack/resp bus between an initiator and a responder
interface scr1_mem_responder_if #(
  parameter int AWIDTH = 32
);
  logic              req;
  logic [1:0]        cmd;
  logic [1:0]        width;
  logic [AWIDTH-1:0] addr;
  logic [31:0]       wdata;
  logic              ack_stall;
  logic              req_ack;
  logic [31:0]       rdata;
  logic [1:0]        resp;
  modport master (output req, cmd, width, addr, wdata, ack_stall, input req_ack, rdata, resp);
  modport slave  (input req, cmd, width, addr, wdata, ack_stall, output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_mem_responder.sv
// scr1_mem_responder: single-outstanding SCR1 memory slave with internal RAM and fixed response latency
module scr1_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int AWIDTH  = 32
) (
  input logic                  clk,
  input logic                  pipe_rst,
  scr1_mem_responder_if.slave  bus
);
  localparam int         IW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $fatal(1, "scr1_mem_responder: LATENCY must be within 1..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "scr1_mem_responder: DEPTH must be a power of 2");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e         state, state_nx;
  logic [3:0]     cnt;
  logic [1:0]     resp_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [DEPTH];
  logic           acc, err, rd;
  logic [3:0]     be;
  logic [IW-1:0]  widx;
  // classify the request presented this cycle; only meaningful when it is accepted
  always_comb begin
    acc  = bus.req & bus.req_ack;
    rd   = bus.cmd == 2'd0;
    widx = bus.addr[IW+1:2];
    err  = bus.cmd[1] | (&bus.width) | (bus.width == 2'd1 & bus.addr[0]) |
           (bus.width == 2'd2 & |bus.addr[1:0]) |
           (bus.addr[AWIDTH-1:2] >= (AWIDTH-2)'(DEPTH));
    be   = bus.width == 2'd2 ? 4'hF : bus.width == 2'd1 ? 4'b0011 << bus.addr[1:0] : 4'b0001 << bus.addr[1:0];
  end
  // state register
  always_ff @(posedge clk) begin
    if (pipe_rst) state <= IDLE;
    else          state <= state_nx;
  end
  // next state: accept starts a new response countdown, otherwise drain WAIT or fall back to IDLE
  always_comb begin
    state_nx = acc ? (LATENCY == 1 ? RESP : WAIT) : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  // outputs are forced quiet while reset is held so a pending response is never shown
  always_comb begin
    bus.req_ack = ~pipe_rst & ~bus.ack_stall & (state != WAIT);
    bus.resp    = (~pipe_rst & state == RESP) ? resp_q : 2'd0;
    bus.rdata   = (~pipe_rst & state == RESP) ? rdata_q : 32'd0;
  end
  // capture response code, read data and latency count at the accept edge
  always_ff @(posedge clk) begin
    if (pipe_rst) begin
      cnt     <= 4'd0;
      resp_q  <= 2'd0;
      rdata_q <= 32'd0;
    end else if (acc) begin
      cnt     <= LAT_M1;
      resp_q  <= err ? 2'd2 : 2'd1;
      rdata_q <= (rd & ~err) ? mem[widx] : 32'd0;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end
  // byte-lane write commit at the accept edge; RAM is deliberately not reset
  always_ff @(posedge clk) begin
    if (acc & ~err & ~rd)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_scr1_mem_responder.sv
// tb_scr1_mem_responder: randomized check of two responders (LATENCY 1 and 4) against a byte-level memory model
module tb_scr1_mem_responder;
  localparam int DEPTH = 64;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, BY = 2'd0, HW = 2'd1, WD = 2'd2;
  logic        clk = 1'b0;
  logic        rst, req, stall1, stall4;
  logic [1:0]  cmd, width;
  logic [31:0] addr, wdata;
  logic        ack;
  logic [1:0]  resp;
  logic [31:0] rdata;
  int          cur, total, bad;
  logic [31:0] mem_m [2][DEPTH];
  always #5 clk = ~clk;
  scr1_mem_responder_if #(.AWIDTH(32)) b1 ();
  scr1_mem_responder_if #(.AWIDTH(32)) b4 ();
  assign b1.req = req;  assign b1.cmd = cmd;  assign b1.width = width;
  assign b1.addr = addr;  assign b1.wdata = wdata;  assign b1.ack_stall = stall1;
  assign b4.req = req;  assign b4.cmd = cmd;  assign b4.width = width;
  assign b4.addr = addr;  assign b4.wdata = wdata;  assign b4.ack_stall = stall4;
  assign ack   = cur != 0 ? b4.req_ack : b1.req_ack;
  assign resp  = cur != 0 ? b4.resp : b1.resp;
  assign rdata = cur != 0 ? b4.rdata : b1.rdata;
  scr1_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .AWIDTH(32)) u1 (.clk(clk), .pipe_rst(rst), .bus(b1));
  scr1_mem_responder #(.DEPTH(DEPTH), .LATENCY(4), .AWIDTH(32)) u4 (.clk(clk), .pipe_rst(rst), .bus(b4));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model(input int d, input logic [1:0] c, input logic [1:0] w, input logic [31:0] a,
                                input logic [31:0] wd, output logic [1:0] r, output logic [31:0] rd);
    int unsigned sz, lane;
    sz = w == 2'd0 ? 1 : w == 2'd1 ? 2 : 4;
    rd = 32'd0;
    if (c > 2'd1 || w > 2'd2 || (a % sz) != 0 || (a / 4) >= DEPTH) r = 2'd2;
    else begin
      r = 2'd1;
      if (c == RD) rd = mem_m[d][a / 4];
      else
        for (int unsigned k = 0; k < sz; k++) begin
          lane = (a + k) % 4;
          mem_m[d][a / 4][8*lane +: 8] = wd[8*lane +: 8];
        end
    end
  endfunction
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk); #1;
      check("idle_resp", 32'(resp), 32'd0);
      check("idle_rdata", rdata, 32'd0);
    end
  endtask
  task automatic txn(input int d, input logic [1:0] c, input logic [1:0] w, input logic [31:0] a,
                     input logic [31:0] wd, input int nstall, input int abort);
    logic [1:0]  er;
    logic [31:0] ed;
    int          n, lat;
    lat = d != 0 ? 4 : 1;
    req = 1'b1; cmd = c; width = w; addr = a; wdata = wd;
    if (nstall > 0) begin
      if (d != 0) stall4 = 1'b1; else stall1 = 1'b1;
      for (int i = 0; i < nstall; i++) begin
        #1 check("stall_ack", 32'(ack), 32'd0);
        @(posedge clk); @(negedge clk);
      end
      if (d != 0) stall4 = 1'b0; else stall1 = 1'b0;
    end
    #1 n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); @(negedge clk); #1;
      n++;
    end
    check("ack_wait", 32'(n), 32'd0);
    model(d, c, w, a, wd, er, ed);
    @(posedge clk);
    #1 req = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk); #1;
      if (abort == i) begin
        rst = 1'b1;
        #1 check("abort_resp", 32'(resp), 32'd0);
        repeat (2) begin
          @(posedge clk); @(negedge clk); #1;
          check("abort_rst_ack", 32'(ack), 32'd0);
          check("abort_rst_resp", 32'(resp), 32'd0);
        end
        rst = 1'b0;
        idle(6);
        return;
      end
      if (i < lat) begin
        check("wait_resp", 32'(resp), 32'd0);
        check("wait_ack", 32'(ack), 32'd0);
        check("wait_rdata", rdata, 32'd0);
      end else begin
        check("resp", 32'(resp), 32'(er));
        check("rdata", rdata, ed);
      end
    end
  endtask
  task automatic select(input int d);
    cur = d;
    stall1 = d != 0;
    stall4 = d == 0;
  endtask
  initial begin
    total = 0; bad = 0; cur = 0;
    rst = 1'b1; req = 1'b1; stall1 = 1'b0; stall4 = 1'b0;
    cmd = RD; width = WD; addr = 32'd0; wdata = 32'd0;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_ack1", 32'(b1.req_ack), 32'd0);
      check("rst_ack4", 32'(b4.req_ack), 32'd0);
      check("rst_resp1", 32'(b1.resp), 32'd0);
      check("rst_resp4", 32'(b4.resp), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1 check("rel_ack1", 32'(b1.req_ack), 32'd1);
    check("rel_ack4", 32'(b4.req_ack), 32'd1);
    select(0);
    txn(0, WR, WD, 32'h10, 32'hDEADBEEF, 0, 0);
    txn(0, RD, WD, 32'h10, 32'h0, 0, 0);
    txn(0, WR, WD, 32'h20, 32'h11223344, 0, 0);
    txn(0, WR, BY, 32'h21, 32'h0000AA00, 0, 0);
    txn(0, WR, HW, 32'h22, 32'hBBBB0000, 0, 0);
    txn(0, RD, WD, 32'h20, 32'h0, 0, 0);
    check("lanes_word", mem_m[0][8], 32'hBBBBAA44);
    txn(0, WR, HW, 32'h23, 32'hCCCCCCCC, 0, 0);
    txn(0, RD, WD, 32'h20, 32'h0, 0, 0);
    txn(0, RD, WD, DEPTH * 4, 32'h0, 0, 0);
    txn(0, 2'd2, WD, 32'h10, 32'h0, 0, 0);
    txn(0, RD, 2'd3, 32'h10, 32'h0, 0, 0);
    txn(0, RD, BY, 32'h13, 32'h0, 0, 0);
    idle(2);
    select(1);
    txn(1, WR, WD, 32'h10, 32'hCAFEF00D, 2, 0);
    txn(1, RD, HW, 32'h12, 32'h0, 2, 0);
    txn(1, WR, WD, 32'h40, 32'h5A5A5A5A, 0, 2);
    txn(1, RD, WD, 32'h40, 32'h0, 0, 0);
    check("abort_commit", mem_m[1][16], 32'h5A5A5A5A);
    for (int d = 0; d < 2; d++) begin
      idle(1);
      select(d);
      for (int i = 0; i < DEPTH; i++) txn(d, WR, WD, 32'(i * 4), $urandom, 0, 0);
      for (int i = 0; i < 200; i++) begin
        logic [1:0]  c, w;
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        c = r < 4 ? RD : r < 9 ? WR : 2'($urandom_range(2, 3));
        w = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
        a = $urandom_range(0, 9) == 0 ? 32'($urandom_range(DEPTH * 4, DEPTH * 4 + 64)) : 32'($urandom_range(0, DEPTH * 4 - 1));
        txn(d, c, w, a, $urandom, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0, 0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
